key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 13 +
 rtl/key_debounce.sv | 132 +++++++++++++
 tb/tb_key_debounce.sv | 139 +++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if: pushbutton signal bundle between a key source and the debouncer
// Signals: key_in raw active-low key; key_level debounced state (1 = pressed);
//   key_press, key_release, key_long one-cycle event pulses.
// Modports: master drives key_in and observes the outputs; slave is the debouncer side.
interface key_debounce_if;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;
    modport master (output key_in, input key_level, key_press, key_release, key_long);
    modport slave (input key_in, output key_level, key_press, key_release, key_long);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: pushbutton debouncer with press/release/long-press pulses
// Ports: clk system clock; rst_n async active-low reset;
//   io_key (key_debounce_if.slave): key_in raw active-low key in, key_level
//   debounced state out, key_press/key_release/key_long one-cycle pulses out.
// Optional: define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press detector;
//   otherwise key_long is tied low.
module key_debounce #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [24:0] LONG_MAX = 25'd24_999_999
) (
    input logic         clk,
    input logic         rst_n,
    key_debounce_if.slave io_key
);
    localparam int CW = $bits(CNT_MAX);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]    r_sync;
    logic          w_key_s;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    // Synchronizer idles high to match an unpressed key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], io_key.key_in};
    end

    assign w_key_s = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_key_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (w_key_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (w_key_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    // A low sample during release debounce is a bounce: back to PRESSED silently.
                    if (!w_key_s) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign io_key.key_level   = r_level;
    assign io_key.key_press   = r_press;
    assign io_key.key_release = r_release;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int LW = $bits(LONG_MAX);
    logic [LW-1:0] r_long_cnt;
    logic          r_long_done;
    logic          r_long;

    // Counts only while PRESSED, holds through release bounces, and saturates
    // so the pulse fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (r_state == IDLE) begin
                r_long_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (r_state == PRESSED) begin
                if (r_long_cnt != LONG_MAX) begin
                    r_long_cnt <= r_long_cnt + LW'(1);
                end else if (!r_long_done) begin
                    r_long      <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end
        end
    end

    assign io_key.key_long = r_long;
`else
    // LONG_MAX only matters when the long-press detector is built.
    logic w_unused_long;
    assign w_unused_long   = ^LONG_MAX;
    assign io_key.key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench for key_debounce with CNT_MAX=9, LONG_MAX=30
module tb_key_debounce;
    localparam int CNT = 9;
    localparam int P = 0;
    localparam int R = 1;
    localparam int L = 2;
    localparam int NONE = -1;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int EXP_LONG = 1;
`else
    localparam int EXP_LONG = 0;
`endif

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t   q[$];
    string nm[3] = '{"press", "release", "long"};
    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    edge_n = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    n_long = 0;

    key_debounce_if kif();

    key_debounce #(.CNT_MAX(20'd9), .LONG_MAX(25'd30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_key(kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic pop(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected %s: got pulse at edge %0d, expected none", nm[kind], edge_n - 1);
        end else begin
            e = q.pop_front();
            check($sformatf("%s kind", nm[kind]), kind, e.kind);
            check($sformatf("%s edge", nm[kind]), edge_n - 1, e.at);
        end
    endtask

    // Monitor: pulses are sampled on the falling edge and matched in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (kif.key_press || kif.key_release)
                check("press/release exclusive", int'(kif.key_press & kif.key_release), 0);
            if (kif.key_press) begin
                pop(P);
                check("level on press", int'(kif.key_level), 1);
            end
            if (kif.key_release) begin
                pop(R);
                check("level on release", int'(kif.key_level), 0);
            end
            if (kif.key_long) begin
                n_long++;
                pop(L);
            end
        end
    end

    // Drive key_in from a falling edge for n cycles; an expected pulse lands
    // CNT+3 edges after the first edge that samples the new level.
    task automatic hold(input logic v, input int n, input int kind, output int e);
        kif.key_in = v;
        e = edge_n;
        if (kind != NONE) q.push_back('{kind, e + CNT + 3});
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " level"}, int'(kif.key_level), 0);
        check({tag, " press"}, int'(kif.key_press), 0);
        check({tag, " release"}, int'(kif.key_release), 0);
        check({tag, " long"}, int'(kif.key_long), 0);
    endtask

    initial begin
        int e;
        kif.key_in = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Clean press and release.
        hold(1'b0, 20, P, e);
        check("level after press", int'(kif.key_level), 1);
        hold(1'b1, 20, R, e);
        check("level after release", int'(kif.key_level), 0);
        // Press bounce: 5 low, 3 high, then stable low.
        hold(1'b0, 5, NONE, e);
        hold(1'b1, 3, NONE, e);
        hold(1'b0, 20, P, e);
        hold(1'b1, 20, R, e);
        // Release bounce: 4 high then low again must not release.
        hold(1'b0, 20, P, e);
        hold(1'b1, 4, NONE, e);
        hold(1'b0, 20, NONE, e);
        check("level through release bounce", int'(kif.key_level), 1);
        hold(1'b1, 20, R, e);
        check("level after bounced release", int'(kif.key_level), 0);
        // Long hold: PRESSED is entered at edge e+12, long pulse 31 edges later.
        n_long = 0;
        hold(1'b0, 0, P, e);
        if (EXP_LONG != 0) q.push_back('{L, e + CNT + 3 + 31});
        repeat (72) @(negedge clk);
        check("long pulse count", n_long, EXP_LONG);
        hold(1'b1, 20, R, e);
        // Reset mid-press aborts silently; a held key is re-debounced.
        hold(1'b0, 20, P, e);
        check("level before reset", int'(kif.key_level), 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 20, P, e);
        check("level after re-press", int'(kif.key_level), 1);
        hold(1'b1, 20, R, e);
        check("pending events", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
